// File: rtl/stack_reg_file.sv
// stack_reg_file: register file with addressed save/load access and a
// push/pop hardware stack that share the same storage.
//
// Ports:
//   clk_i      - clock, all state changes on the rising edge
//   reset_i    - synchronous active-high reset (clears sp, err and all entries)
//   save_i     - write in_i to mem[addr_i]
//   load_i     - drive mem[addr_i] onto out_o
//   addr_i     - entry index for save/load
//   push_i     - write in_i at mem[sp], sp+1
//   pop_i      - drive mem[sp-1] onto out_o, sp-1
//   clr_err_i  - clear the sticky error flag
//   in_i       - write data
//   out_o      - read data (combinational)
//   sp_o       - stack pointer, number of stacked entries (0..DEPTH)
//   full_o     - sp == DEPTH
//   empty_o    - sp == 0
//   err_o      - sticky overflow/underflow flag
module stack_reg_file #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             save_i,
  input  logic             load_i,
  input  logic [AW-1:0]    addr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clr_err_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic [AW:0]      sp_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      sp_q, sp_d;
  logic             err_q, err_d;

  logic             full_c, empty_c;
  logic [AW-1:0]    top_idx_c;
  logic [AW-1:0]    push_idx_c;
  logic             stack_we_c;
  logic [AW-1:0]    stack_idx_c;
  logic             save_we_c;
  logic             new_err_c;

  // Status flags decoded from the pointer.
  assign full_c  = (sp_q == SP_FULL);
  assign empty_c = (sp_q == '0);

  // Top-of-stack index; at sp == DEPTH the low bits are 0 and wrap to DEPTH-1.
  assign top_idx_c  = sp_q[AW-1:0] - AW'(1);
  // Only meaningful when not full.
  assign push_idx_c = sp_q[AW-1:0];

  // Stack command decode: pointer update, stack write and error detection.
  always_comb begin
    sp_d        = sp_q;
    stack_we_c  = 1'b0;
    stack_idx_c = '0;
    new_err_c   = 1'b0;
    if (push_i && pop_i) begin
      stack_we_c = 1'b1;
      if (empty_c) begin
        // Replace on an empty stack degenerates to a plain push.
        stack_idx_c = '0;
        sp_d        = (AW+1)'(1);
      end else begin
        stack_idx_c = top_idx_c;
      end
    end else if (push_i) begin
      if (full_c) begin
        new_err_c = 1'b1;
      end else begin
        stack_we_c  = 1'b1;
        stack_idx_c = push_idx_c;
        sp_d        = sp_q + (AW+1)'(1);
      end
    end else if (pop_i) begin
      if (empty_c) begin
        new_err_c = 1'b1;
      end else begin
        sp_d = sp_q - (AW+1)'(1);
      end
    end
  end

  // Addressed save loses to a stack write aimed at the same entry.
  assign save_we_c = save_i && !(stack_we_c && (stack_idx_c == addr_i));

  // Sticky error: a new error beats a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (new_err_c) begin
      err_d = 1'b1;
    end else if (clr_err_i) begin
      err_d = 1'b0;
    end
  end

  // State and storage update.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
      if (save_we_c) begin
        mem_q[addr_i] <= in_i;
      end
      if (stack_we_c) begin
        mem_q[stack_idx_c] <= in_i;
      end
    end
  end

  // Read mux: pop has priority over load; pop on an empty stack reads 0.
  always_comb begin
    out_o = '0;
    if (pop_i) begin
      if (!empty_c) begin
        out_o = mem_q[top_idx_c];
      end
    end else if (load_i) begin
      out_o = mem_q[addr_i];
    end
  end

  assign sp_o    = sp_q;
  assign full_o  = full_c;
  assign empty_o = empty_c;
  assign err_o   = err_q;

endmodule

// File: tb/tb_stack_reg_file.sv
// tb_stack_reg_file: directed and randomized checks of stack_reg_file
// against an array-plus-count reference model of the stack/register file.
module tb_stack_reg_file;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic             clk;
  logic             reset;
  logic             save, load, push, pop, clr_err;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [AW:0]      sp;
  logic             full, empty, err;

  int checks = 0;
  int errors = 0;

  // Reference model: flat storage, a count of stacked entries, a sticky flag.
  int m_mem [DEPTH];
  int m_sp;
  bit m_err;

  // Values seen on the most recent step, for directed literal checks.
  int obs_out, obs_sp;
  bit obs_full, obs_empty, obs_err;

  stack_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .save_i    (save),
    .load_i    (load),
    .addr_i    (addr),
    .push_i    (push),
    .pop_i     (pop),
    .clr_err_i (clr_err),
    .in_i      (din),
    .out_o     (dout),
    .sp_o      (sp),
    .full_o    (full),
    .empty_o   (empty),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sp  = 0;
    m_err = 1'b0;
    foreach (m_mem[i]) m_mem[i] = 0;
  endtask

  // One cycle of commands: drive, check combinational view, clock, update model.
  task automatic step(input bit sv, input bit ld, input int ad, input bit ps,
                      input bit pp, input bit cl, input int d);
    int exp_out;
    int wr_idx;
    bit bad;
    save = sv; load = ld; addr = AW'(ad); push = ps; pop = pp;
    clr_err = cl; din = WIDTH'(d);
    #2;
    if (pp)      exp_out = (m_sp == 0) ? 0 : m_mem[m_sp - 1];
    else if (ld) exp_out = m_mem[ad];
    else         exp_out = 0;
    obs_out = int'(dout); obs_sp = int'(sp);
    obs_full = full; obs_empty = empty; obs_err = err;
    chk("out",   obs_out, exp_out);
    chk("sp",    obs_sp, m_sp);
    chk("full",  int'(obs_full), int'(m_sp == int'(DEPTH)));
    chk("empty", int'(obs_empty), int'(m_sp == 0));
    chk("err",   int'(obs_err), int'(m_err));
    @(posedge clk);
    #1;
    wr_idx = -1;
    bad    = 1'b0;
    if (ps && pp) begin
      wr_idx = (m_sp == 0) ? 0 : m_sp - 1;
      if (m_sp == 0) m_sp = 1;
    end else if (ps) begin
      if (m_sp == int'(DEPTH)) bad = 1'b1;
      else begin wr_idx = m_sp; m_sp++; end
    end else if (pp) begin
      if (m_sp == 0) bad = 1'b1;
      else m_sp--;
    end
    if (sv && ad != wr_idx) m_mem[ad] = d & 8'hFF;
    if (wr_idx >= 0)        m_mem[wr_idx] = d & 8'hFF;
    if (bad)     m_err = 1'b1;
    else if (cl) m_err = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset with random commands present; all of them must be discarded.
  task automatic do_reset();
    reset = 1'b1;
    save = 1'($urandom); load = 1'($urandom); push = 1'($urandom);
    pop = 1'($urandom); clr_err = 1'($urandom);
    addr = AW'($urandom); din = WIDTH'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; save = 0; load = 0; push = 0; pop = 0; clr_err = 0;
    addr = '0; din = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Reset state: every entry reads zero.
    for (int a = 0; a < int'(DEPTH); a++) begin
      step(0, 1, a, 0, 0, 0, 0);
      chk("rst_load", obs_out, 0);
    end
    chk("rst_empty", int'(obs_empty), 1);
    chk("rst_sp", obs_sp, 0);
    chk("rst_err", int'(obs_err), 0);

    // No write-to-read bypass.
    step(1, 1, 3, 0, 0, 0, 'hA5);
    chk("save_old", obs_out, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    chk("save_new", obs_out, 'hA5);

    // LIFO order and underflow.
    step(0, 0, 0, 1, 0, 0, 'h11);
    step(0, 0, 0, 1, 0, 0, 'h22);
    step(0, 0, 0, 1, 0, 0, 'h33);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("pop0_sp", obs_sp, 3);
    chk("pop0", obs_out, 'h33);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("pop1", obs_out, 'h22);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("pop2", obs_out, 'h11);
    step(0, 1, 3, 0, 1, 0, 0);
    chk("pop_empty_out", obs_out, 0);
    chk("pop_empty_flag", int'(obs_empty), 1);
    idle();
    chk("uflow_err", int'(obs_err), 1);
    chk("uflow_sp", obs_sp, 0);
    // Clear racing a new error keeps err set.
    step(0, 0, 0, 0, 1, 1, 0);
    idle();
    chk("clr_vs_err", int'(obs_err), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("clr_err", int'(obs_err), 0);

    // Fill to full, then overflow.
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) step(0, 0, 0, 1, 0, 0, i);
    idle();
    chk("full", int'(obs_full), 1);
    step(0, 0, 0, 1, 0, 0, 'hFF);
    step(0, 1, 15, 0, 0, 0, 0);
    chk("oflow_sp", obs_sp, 16);
    chk("oflow_err", int'(obs_err), 1);
    chk("oflow_mem15", obs_out, 15);
    step(0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("oflow_clr", int'(obs_err), 0);

    // Replace top.
    do_reset();
    step(0, 0, 0, 1, 0, 0, 'h11);
    step(0, 0, 0, 1, 0, 0, 'h22);
    step(0, 0, 0, 1, 1, 0, 'h77);
    chk("repl_out", obs_out, 'h22);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("repl_sp", obs_sp, 2);
    chk("repl_pop", obs_out, 'h77);
    // Replace on empty behaves as push.
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 'h5C);
    chk("repl_empty_out", obs_out, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("repl_empty_sp", obs_sp, 1);
    chk("repl_empty_mem0", obs_out, 'h5C);
    chk("repl_empty_err", int'(obs_err), 0);

    // Stack write beats save to the same entry; reset mid-stack.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 'h60 + i);
    step(1, 0, 5, 1, 0, 0, 'h44);
    save = 1'b1; push = 1'b0; addr = 4'd5; din = 8'h99;
    step(0, 1, 5, 0, 0, 0, 0);
    chk("collide_mem5", obs_out, 'h44);
    chk("collide_sp", obs_sp, 6);
    do_reset();
    step(0, 1, 5, 0, 0, 0, 0);
    chk("midrst_mem5", obs_out, 0);
    chk("midrst_sp", obs_sp, 0);
    chk("midrst_empty", int'(obs_empty), 1);

    // Random mix of all commands.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) do_reset();
      else step(($urandom_range(0, 3) == 0), 1'($urandom),
                int'($urandom_range(0, DEPTH - 1)),
                ($urandom_range(0, 9) < (n % 200 < 100 ? 6 : 3)),
                ($urandom_range(0, 9) < (n % 200 < 100 ? 3 : 6)),
                ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
